hyperram_cmd_arbiter: RTL and testbench

Shares the single HyperRAM transaction engine between `NUM_REQ` independent requesters, for example the VIO debug port and an on-chip register poller. The block arbitrates round-robin, latches the winning command, and pulses the engine start. It then waits for engine completion or a timeout, and routes the read data back to the owning requester. A mandatory idle gap after every transaction guarantees the HyperRAM CS# high time before the next transaction is issued. The block sits between the requesters and the HyperRAM engine in `top`, all on the `clk` domain from the clock wizard.

---
 rtl/hyperram_cmd_arbiter_pkg.sv | 17 +
 rtl/hyperram_cmd_arbiter_if.sv | 37 +++
 rtl/hyperram_cmd_arbiter_rr_pick.sv | 32 +++
 rtl/hyperram_cmd_arbiter.sv | 172 +++++++++++++++++
 tb/tb_hyperram_cmd_arbiter.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/hyperram_cmd_arbiter_pkg.sv
// Shared types and constants for the HyperRAM command arbiter.
//   arb_state_t : arbiter FSM state encoding
//   HR_DATA_W   : width of a HyperRAM write word
//   HR_RDATA_W  : width of the engine read-data word
package hyperram_pkg;

    localparam int unsigned HR_DATA_W  = 16;
    localparam int unsigned HR_RDATA_W = 32;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StGap
    } arb_state_t;

endpackage

// File: rtl/hyperram_cmd_arbiter_if.sv
// Bundle of the requester-side and engine-side signals of the HyperRAM command arbiter.
//   slave  : arbiter view (takes requests and engine completion, drives grants/responses/command)
//   master : environment view (requesters plus the transaction engine)
// Requester signals are packed; requester i occupies slice i.
interface hyperram_cmd_arbiter_if #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ADDR_W  = 32
) ();
    import hyperram_pkg::*;

    logic [NUM_REQ-1:0]           req;
    logic [NUM_REQ*ADDR_W-1:0]    req_addr;
    logic [NUM_REQ-1:0]           req_we;
    logic [NUM_REQ*HR_DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]           gnt;
    logic [NUM_REQ-1:0]           rsp_valid;
    logic [HR_RDATA_W-1:0]        rsp_rdata;
    logic                         rsp_err;

    logic                         eng_start;
    logic [ADDR_W-1:0]            eng_addr;
    logic                         eng_we;
    logic [HR_DATA_W-1:0]         eng_wdata;
    logic                         eng_done;
    logic [HR_RDATA_W-1:0]        eng_rdata;

    modport slave (
        input  req, req_addr, req_we, req_wdata, eng_done, eng_rdata,
        output gnt, rsp_valid, rsp_rdata, rsp_err, eng_start, eng_addr, eng_we, eng_wdata
    );

    modport master (
        output req, req_addr, req_we, req_wdata, eng_done, eng_rdata,
        input  gnt, rsp_valid, rsp_rdata, rsp_err, eng_start, eng_addr, eng_we, eng_wdata
    );

endinterface

// File: rtl/hyperram_cmd_arbiter_rr_pick.sv
// Combinational round-robin selector.
//   i_req      : per-requester request levels
//   i_last_gnt : index of the most recently granted requester
//   o_valid    : at least one request is present
//   o_idx      : first requesting index scanning upward from i_last_gnt+1, wrapping
module rr_pick #(
    parameter int unsigned NUM_REQ = 2,
    localparam int unsigned IDX_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last_gnt,
    output logic               o_valid,
    output logic [IDX_W-1:0]   o_idx
);

    logic [IDX_W-1:0] w_cand;

    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        w_cand  = '0;
        // Walk from farthest to nearest so the nearest requester after last_gnt is written last.
        for (int k = int'(NUM_REQ); k >= 1; k--) begin
            w_cand = IDX_W'((int'(i_last_gnt) + k) % int'(NUM_REQ));
            if (i_req[w_cand]) begin
                o_valid = 1'b1;
                o_idx   = w_cand;
            end
        end
    end

endmodule

// File: rtl/hyperram_cmd_arbiter.sv
// Round-robin arbiter sharing one HyperRAM transaction engine between NUM_REQ requesters.
// Latches the winning command, pulses the engine start, waits for done or timeout, returns the
// response to the owner and enforces an idle gap before the next command.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : requester and engine signals (slave modport)
//   o_busy     : high in every state except idle
// All outputs are registered.
module hyperram_cmd_arbiter
    import hyperram_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned GAP_CYCLES     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    hyperram_cmd_arbiter_if.slave bus,
    output logic                  o_busy
);

    localparam int unsigned      IDX_W     = $clog2(NUM_REQ);
    localparam int unsigned      TO_W      = $clog2(TIMEOUT_CYCLES);
    localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(NUM_REQ - 1);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]       GAP_LAST  = 8'(GAP_CYCLES - 1);

    arb_state_t             r_state, w_state_nxt;
    logic [IDX_W-1:0]       r_last_gnt, w_last_gnt_nxt;
    logic [IDX_W-1:0]       r_owner, w_owner_nxt;
    logic [TO_W-1:0]        r_to_cnt, w_to_cnt_nxt;
    logic [7:0]             r_gap_cnt, w_gap_cnt_nxt;
    logic [NUM_REQ-1:0]     r_gnt, w_gnt_nxt;
    logic                   r_eng_start, w_eng_start_nxt;
    logic [ADDR_W-1:0]      r_eng_addr, w_eng_addr_nxt;
    logic                   r_eng_we, w_eng_we_nxt;
    logic [HR_DATA_W-1:0]   r_eng_wdata, w_eng_wdata_nxt;
    logic [NUM_REQ-1:0]     r_rsp_valid, w_rsp_valid_nxt;
    logic [HR_RDATA_W-1:0]  r_rsp_rdata, w_rsp_rdata_nxt;
    logic                   r_rsp_err, w_rsp_err_nxt;
    logic                   r_busy, w_busy_nxt;

    logic                   w_pick_valid;
    logic [IDX_W-1:0]       w_pick_idx;
    logic [ADDR_W-1:0]      w_addr_arr  [NUM_REQ];
    logic [HR_DATA_W-1:0]   w_wdata_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_addr_arr[g]  = bus.req_addr[g*ADDR_W +: ADDR_W];
        assign w_wdata_arr[g] = bus.req_wdata[g*HR_DATA_W +: HR_DATA_W];
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .i_req      (bus.req),
        .i_last_gnt (r_last_gnt),
        .o_valid    (w_pick_valid),
        .o_idx      (w_pick_idx)
    );

    always_comb begin
        w_state_nxt     = r_state;
        w_last_gnt_nxt  = r_last_gnt;
        w_owner_nxt     = r_owner;
        w_to_cnt_nxt    = r_to_cnt;
        w_gap_cnt_nxt   = r_gap_cnt;
        w_gnt_nxt       = '0;
        w_eng_start_nxt = 1'b0;
        w_eng_addr_nxt  = r_eng_addr;
        w_eng_we_nxt    = r_eng_we;
        w_eng_wdata_nxt = r_eng_wdata;
        w_rsp_valid_nxt = '0;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_rsp_err_nxt   = r_rsp_err;

        case (r_state)
            StIdle: begin
                if (w_pick_valid) begin
                    w_owner_nxt             = w_pick_idx;
                    w_eng_addr_nxt          = w_addr_arr[w_pick_idx];
                    w_eng_we_nxt            = bus.req_we[w_pick_idx];
                    w_eng_wdata_nxt         = w_wdata_arr[w_pick_idx];
                    // Grant and start are registered so they appear during the ISSUE cycle.
                    w_gnt_nxt[w_pick_idx]   = 1'b1;
                    w_eng_start_nxt         = 1'b1;
                    w_state_nxt             = StIssue;
                end
            end
            StIssue: begin
                w_last_gnt_nxt = r_owner;
                w_to_cnt_nxt   = '0;
                w_state_nxt    = StWait;
            end
            StWait: begin
                // done is tested first so it wins a tie with the timeout.
                if (bus.eng_done) begin
                    w_rsp_rdata_nxt          = bus.eng_rdata;
                    w_rsp_err_nxt            = 1'b0;
                    w_rsp_valid_nxt[r_owner] = 1'b1;
                    w_gap_cnt_nxt            = '0;
                    w_state_nxt              = StGap;
                end else if (r_to_cnt == TO_LAST) begin
                    w_rsp_rdata_nxt          = '0;
                    w_rsp_err_nxt            = 1'b1;
                    w_rsp_valid_nxt[r_owner] = 1'b1;
                    w_gap_cnt_nxt            = '0;
                    w_state_nxt              = StGap;
                end else if (r_to_cnt != '1) begin
                    w_to_cnt_nxt = r_to_cnt + 1'b1;
                end
            end
            StGap: begin
                if (r_gap_cnt == GAP_LAST) begin
                    w_state_nxt = StIdle;
                end else if (r_gap_cnt != 8'hFF) begin
                    w_gap_cnt_nxt = r_gap_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase

        w_busy_nxt = (w_state_nxt != StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_last_gnt  <= LAST_INIT;
            r_owner     <= '0;
            r_to_cnt    <= '0;
            r_gap_cnt   <= '0;
            r_gnt       <= '0;
            r_eng_start <= 1'b0;
            r_eng_addr  <= '0;
            r_eng_we    <= 1'b0;
            r_eng_wdata <= '0;
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_last_gnt  <= w_last_gnt_nxt;
            r_owner     <= w_owner_nxt;
            r_to_cnt    <= w_to_cnt_nxt;
            r_gap_cnt   <= w_gap_cnt_nxt;
            r_gnt       <= w_gnt_nxt;
            r_eng_start <= w_eng_start_nxt;
            r_eng_addr  <= w_eng_addr_nxt;
            r_eng_we    <= w_eng_we_nxt;
            r_eng_wdata <= w_eng_wdata_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    assign bus.gnt       = r_gnt;
    assign bus.eng_start = r_eng_start;
    assign bus.eng_addr  = r_eng_addr;
    assign bus.eng_we    = r_eng_we;
    assign bus.eng_wdata = r_eng_wdata;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;
    assign o_busy        = r_busy;

endmodule

// File: tb/tb_hyperram_cmd_arbiter.sv
// Directed self-checking bench for hyperram_cmd_arbiter (NUM_REQ=2, GAP_CYCLES=4,
// TIMEOUT_CYCLES=32). Inputs change and outputs are sampled 1 time unit after the rising edge.
module tb_hyperram_cmd_arbiter;

    localparam int unsigned GAP = 4;
    localparam int unsigned TO  = 32;

    logic clk;
    logic rst_n;
    logic busy;
    int   n_checks;
    int   n_errors;
    int   cyc;
    int   cyc_s;
    int   prev_done;

    hyperram_cmd_arbiter_if #(.NUM_REQ(2), .ADDR_W(32)) bus ();

    hyperram_cmd_arbiter #(
        .NUM_REQ        (2),
        .ADDR_W         (32),
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus),
        .o_busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_gnt"},       32'(bus.gnt),       32'h0);
        check_eq({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'h0);
        check_eq({tag, "_rsp_rdata"}, bus.rsp_rdata,      32'h0);
        check_eq({tag, "_rsp_err"},   32'(bus.rsp_err),   32'h0);
        check_eq({tag, "_eng_start"}, 32'(bus.eng_start), 32'h0);
        check_eq({tag, "_eng_addr"},  bus.eng_addr,       32'h0);
        check_eq({tag, "_eng_we"},    32'(bus.eng_we),    32'h0);
        check_eq({tag, "_eng_wdata"}, 32'(bus.eng_wdata), 32'h0);
        check_eq({tag, "_busy"},      32'(busy),          32'h0);
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && busy; i++) tick();
        check_eq("wait_idle", 32'(busy), 32'h0);
    endtask

    task automatic wait_start(input int budget);
        for (int i = 0; i < budget && !bus.eng_start; i++) tick();
        check_eq("wait_start", 32'(bus.eng_start), 32'h1);
    endtask

    task automatic pulse_done(input logic [31:0] data);
        bus.eng_done  = 1'b1;
        bus.eng_rdata = data;
        tick();
        bus.eng_done  = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        bus.req       = '0;
        bus.req_addr  = '0;
        bus.req_we    = '0;
        bus.req_wdata = '0;
        bus.eng_done  = 1'b0;
        bus.eng_rdata = '0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("rst");
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Single read; both request at first, requester 0 has priority out of reset.
        bus.req      = 2'b11;
        bus.req_addr = {32'h0000_4000, 32'h0000_0800};
        tick();
        check_eq("rd_gnt",   32'(bus.gnt),       32'h1);
        check_eq("rd_start", 32'(bus.eng_start), 32'h1);
        check_eq("rd_addr",  bus.eng_addr,       32'h0000_0800);
        check_eq("rd_we",    32'(bus.eng_we),    32'h0);
        check_eq("rd_busy",  32'(busy),          32'h1);
        bus.req = '0;
        tick();
        check_eq("rd_pulse", 32'({bus.gnt, bus.eng_start}), 32'h0);
        repeat (19) tick();
        check_eq("rd_addr_hold", bus.eng_addr, 32'h0000_0800);
        pulse_done(32'h0C81_0C86);
        check_eq("rd_rsp_valid", 32'(bus.rsp_valid), 32'h1);
        check_eq("rd_rsp_rdata", bus.rsp_rdata,      32'h0C81_0C86);
        check_eq("rd_rsp_err",   32'(bus.rsp_err),   32'h0);
        tick();
        check_eq("rd_rsp_pulse", 32'(bus.rsp_valid), 32'h0);

        // Write from requester 1; inputs are changed after grant to prove latching.
        wait_idle(20);
        bus.req       = 2'b10;
        bus.req_we    = 2'b10;
        bus.req_addr  = {32'h0000_1230, 32'h0};
        bus.req_wdata = {16'h8F1F, 16'h0};
        tick();
        check_eq("wr_gnt",   32'(bus.gnt),       32'h2);
        check_eq("wr_we",    32'(bus.eng_we),    32'h1);
        check_eq("wr_wdata", 32'(bus.eng_wdata), 32'h8F1F);
        check_eq("wr_addr",  bus.eng_addr,       32'h0000_1230);
        bus.req       = '0;
        bus.req_we    = '0;
        bus.req_wdata = '0;
        bus.req_addr  = '0;
        repeat (5) tick();
        check_eq("wr_we_hold",    32'(bus.eng_we),    32'h1);
        check_eq("wr_wdata_hold", 32'(bus.eng_wdata), 32'h8F1F);
        pulse_done(32'h0);
        check_eq("wr_rsp_valid", 32'(bus.rsp_valid), 32'h2);
        check_eq("wr_rsp_err",   32'(bus.rsp_err),   32'h0);

        // Fairness: both held high; last grant was 1, so order is 0,1,0,1,0,1.
        bus.req   = 2'b11;
        prev_done = -1;
        for (int t = 0; t < 6; t++) begin
            wait_start(40);
            check_eq("fair_gnt", 32'(bus.gnt), (t % 2 == 1) ? 32'h2 : 32'h1);
            if (prev_done >= 0) check_eq("fair_spacing", 32'(cyc - prev_done), 32'(GAP + 2));
            if (t == 5) bus.req = '0;
            tick();
            tick();
            pulse_done(32'(t + 16));
            prev_done = cyc - 1;
            check_eq("fair_rsp_valid", 32'(bus.rsp_valid), (t % 2 == 1) ? 32'h2 : 32'h1);
            check_eq("fair_rsp_rdata", bus.rsp_rdata, 32'(t + 16));
        end

        // Timeout: no done ever arrives.
        wait_idle(20);
        bus.req = 2'b01;
        tick();
        cyc_s = cyc;
        check_eq("to_gnt", 32'(bus.gnt), 32'h1);
        bus.req = '0;
        for (int i = 0; i < 100 && bus.rsp_valid == 2'b00; i++) tick();
        check_eq("to_latency",   32'(cyc - cyc_s),   32'(TO + 1));
        check_eq("to_rsp_valid", 32'(bus.rsp_valid), 32'h1);
        check_eq("to_rsp_err",   32'(bus.rsp_err),   32'h1);
        check_eq("to_rsp_rdata", bus.rsp_rdata,      32'h0);
        tick();
        pulse_done(32'h1111_2222);
        check_eq("stray_gap_valid", 32'(bus.rsp_valid), 32'h0);
        check_eq("stray_gap_rdata", bus.rsp_rdata,      32'h0);
        check_eq("stray_gap_err",   32'(bus.rsp_err),   32'h1);
        wait_idle(20);
        pulse_done(32'h3333_4444);
        check_eq("stray_idle_valid", 32'(bus.rsp_valid), 32'h0);
        check_eq("stray_idle_rdata", bus.rsp_rdata,      32'h0);
        check_eq("stray_idle_busy",  32'(busy),          32'h0);

        // done on the final timeout cycle wins.
        bus.req = 2'b10;
        tick();
        cyc_s = cyc;
        check_eq("tie_gnt", 32'(bus.gnt), 32'h2);
        bus.req = '0;
        repeat (TO) tick();
        pulse_done(32'hDEAD_BEEF);
        check_eq("tie_latency",   32'(cyc - cyc_s),   32'(TO + 1));
        check_eq("tie_rsp_valid", 32'(bus.rsp_valid), 32'h2);
        check_eq("tie_rsp_err",   32'(bus.rsp_err),   32'h0);
        check_eq("tie_rsp_rdata", bus.rsp_rdata,      32'hDEAD_BEEF);

        // Asynchronous reset during WAIT.
        wait_idle(20);
        bus.req      = 2'b01;
        bus.req_addr = {32'h0, 32'hABCD_0000};
        tick();
        check_eq("mr_gnt", 32'(bus.gnt), 32'h1);
        bus.req = '0;
        repeat (3) tick();
        check_eq("mr_busy_before", 32'(busy),   32'h1);
        check_eq("mr_addr_before", bus.eng_addr, 32'hABCD_0000);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        tick();
        rst_n = 1'b1;
        tick();
        bus.req = 2'b10;
        tick();
        check_eq("post_rst_gnt", 32'(bus.gnt), 32'h2);
        bus.req = '0;
        tick();
        pulse_done(32'h0000_5A5A);
        check_eq("post_rst_valid", 32'(bus.rsp_valid), 32'h2);
        check_eq("post_rst_rdata", bus.rsp_rdata,      32'h0000_5A5A);
        wait_idle(20);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
